// File: rtl/pixel_word_packer.sv
// pixel_word_packer: packs one pixel per cycle, first pixel in the MSBs, into
// memory words and queues finished words in a 2-entry FIFO for the memory writer.
// Optional feature macro: PACKER_FLUSH_EN adds a flush input that pushes a
// partially filled word with its unfilled low pixels zero.
module pixel_word_packer #(
  parameter int MEM_WORD_BITS = 32,
  parameter int PIXEL_BITS    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PIXEL_BITS-1:0]    pixel_in,
  input  logic                     pixel_valid,
  output logic                     pixel_ready,
  output logic [MEM_WORD_BITS-1:0] word_out,
  output logic                     word_valid,
  input  logic                     word_taken,
  output logic                     partial,
  output logic                     buffer_empty
`ifdef PACKER_FLUSH_EN
  ,
  input  logic                     flush
`endif
);

  localparam int PIX_PER_WORD = MEM_WORD_BITS / PIXEL_BITS;
  localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIX_PER_WORD - 1);

  typedef enum logic [1:0] {
    FIFO_EMPTY,
    FIFO_ONE,
    FIFO_FULL
  } fifo_state_e;

  // Byte index: which pixel slot of the assembly word the next pixel fills.
  logic [IDX_W-1:0]         byte_idx;
  logic [MEM_WORD_BITS-1:0] assembly_q;
  logic [MEM_WORD_BITS-1:0] push_word;

  fifo_state_e              fifo_state;
  fifo_state_e              fifo_state_d;
  logic [MEM_WORD_BITS-1:0] head_q;
  logic [MEM_WORD_BITS-1:0] tail_q;

  logic accept;
  logic pop;
  logic complete_push;
  logic flush_push;
  logic push;

  // Ready depends only on registered state, so word_taken never reaches it combinationally.
  assign pixel_ready = !((byte_idx == LAST_IDX) && (fifo_state == FIFO_FULL));

  // Handshake decode and the push sources (word completion or flush).
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned; a missing default silently infers a latch.
    flush_push    = 1'b0;
    accept        = pixel_valid && pixel_ready;
    pop           = word_taken && (fifo_state != FIFO_EMPTY);
    complete_push = accept && (byte_idx == LAST_IDX);
`ifdef PACKER_FLUSH_EN
    // A flush blocked by a full FIFO is dropped; the caller keeps flush high.
    flush_push    = flush && (byte_idx != '0) && !complete_push &&
                    ((fifo_state != FIFO_FULL) || pop);
`endif
    push          = complete_push || flush_push;
  end

  // Merge an accepted pixel into its slot; this is the word pushed on completion or flush.
  always_comb begin
    push_word = assembly_q;
    for (int k = 0; k < PIX_PER_WORD; k++) begin
      if (accept && (byte_idx == IDX_W'(k))) begin
        push_word[MEM_WORD_BITS-1-k*PIXEL_BITS -: PIXEL_BITS] = pixel_in;
      end
    end
  end

  // Byte index FSM and assembly register; cleared on every push so unused slots read zero.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      byte_idx   <= '0;
      assembly_q <= '0;
    end else if (push) begin
      byte_idx   <= '0;
      assembly_q <= '0;
    end else if (accept) begin
      byte_idx   <= byte_idx + 1'b1;
      assembly_q <= push_word;
    end
  end

  // FIFO state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_state <= FIFO_EMPTY;
    end else begin
      fifo_state <= fifo_state_d;
    end
  end

  // FIFO next state and state-decoded outputs.
  always_comb begin
    fifo_state_d = fifo_state;
    word_valid   = (fifo_state != FIFO_EMPTY);
    partial      = (byte_idx != '0);
    buffer_empty = (byte_idx == '0) && (fifo_state == FIFO_EMPTY);
    unique case (fifo_state)
      FIFO_EMPTY: if (push) fifo_state_d = FIFO_ONE;
      FIFO_ONE: begin
        if (push && !pop)      fifo_state_d = FIFO_FULL;
        else if (!push && pop) fifo_state_d = FIFO_EMPTY;
      end
      FIFO_FULL:  if (pop && !push) fifo_state_d = FIFO_ONE;
      default:    fifo_state_d = FIFO_EMPTY;
    endcase
  end

  // FIFO storage: head feeds word_out directly; the tail shifts forward on pop.
  always_ff @(posedge clk) begin
    // NOTE: the two FIFO entries are reset because word_out must read zero
    // after reset; larger storage arrays would normally be left unreset.
    if (reset) begin
      head_q <= '0;
      tail_q <= '0;
    end else begin
      if (push && ((fifo_state == FIFO_EMPTY) || ((fifo_state == FIFO_ONE) && pop))) begin
        head_q <= push_word;
      end else if (pop && (fifo_state == FIFO_FULL)) begin
        head_q <= tail_q;
      end else if (pop) begin
        head_q <= '0;
      end
      if (push && ((fifo_state == FIFO_FULL) || ((fifo_state == FIFO_ONE) && !pop))) begin
        tail_q <= push_word;
      end
    end
  end

  assign word_out = head_q;

endmodule
